// File: rtl/imem_line_fill.sv
// Instruction-cache line-fill engine: turns one line refill request into a single
// memory burst, assembles the beats into a line and pulses b_dv_i once it is complete.
module imem_line_fill #(
    parameter int LINE_BITS = 256,
    parameter int BEAT_BITS = 64,
    parameter int BLK_LEN   = 59
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BLK_LEN-1:0]   b_addr_i,
    input  logic                 b_rd_i,
    output logic [LINE_BITS-1:0] b_data_i,
    output logic                 b_dv_i,
    output logic                 m_rd,
    output logic [63:0]          m_addr,
    output logic [7:0]           m_len,
    input  logic                 m_ack,
    input  logic                 m_rdv,
    input  logic [BEAT_BITS-1:0] m_rdata,
    output logic                 fill_busy
);

    localparam int BEATS = LINE_BITS / BEAT_BITS;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFS_W = 64 - BLK_LEN;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        BEAT,
        DONE,
        DRAIN
    } state_t;

    state_t               r_state;
    logic [BLK_LEN-1:0]   r_addr;
    logic [CNT_W-1:0]     r_cnt;
    logic [LINE_BITS-1:0] r_line;
    logic                 w_lastBeat;

    assign w_lastBeat = m_rdv && (r_cnt == LAST_BEAT);

    // DRAIN keeps counting beats of an abandoned burst so the bus ends up idle
    // before a new request can go out; the line register is only written in BEAT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_line  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (b_rd_i) begin
                        r_addr  <= b_addr_i;
                        r_cnt   <= '0;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (m_ack) begin
                        r_state <= b_rd_i ? BEAT : DRAIN;
                    end
                end
                BEAT: begin
                    if (m_rdv) begin
                        r_line[int'(r_cnt) * BEAT_BITS +: BEAT_BITS] <= m_rdata;
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_lastBeat) begin
                        r_state <= b_rd_i ? DONE : IDLE;
                    end else if (!b_rd_i) begin
                        r_state <= DRAIN;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                DRAIN: begin
                    if (m_rdv) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_lastBeat) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign b_dv_i    = (r_state == DONE);
    assign m_rd      = (r_state == REQ);
    assign fill_busy = (r_state != IDLE);
    assign m_addr    = {r_addr, {OFS_W{1'b0}}};
    assign m_len     = 8'(BEATS - 1);
    assign b_data_i  = r_line;

endmodule

// File: doc/imem_line_fill.md
Name: imem_line_fill

Overview:
- Line-fill engine sitting directly downstream of the L1 instruction cache's refill port (b_addr_i / b_data_i / b_rd_i / b_dv_i).
- Converts a whole-line refill request into one burst read on the narrower system memory bus.
- Assembles the returned beats into a full cache line and hands it to the cache with a single-cycle data-valid pulse.
- Owns all refill sequencing, including abandoning a fill whose requester has gone away.

Parameters:
- LINE_BITS, 256, cache line width in bits; must be a power of two and a multiple of BEAT_BITS.
- BEAT_BITS, 64, memory data bus width in bits.
- BLK_LEN, 59, line (block) address width; equals 64 - log2(LINE_BITS/8).
- BEATS (derived), LINE_BITS/BEAT_BITS; CNT_W = max(1, log2(BEATS)).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- b_addr_i  in  BLK_LEN  line address of the requested refill
- b_rd_i  in  1  refill request; held high by the cache until b_dv_i
- b_data_i  out  LINE_BITS  assembled line; beat k occupies bits [k*BEAT_BITS +: BEAT_BITS]
- b_dv_i  out  1  one-cycle pulse, line valid on b_data_i
- m_rd  out  1  burst read request, address phase
- m_addr  out  64  byte address, {line address, (64-BLK_LEN) zero bits}
- m_len  out  8  beats minus one, constant BEATS-1
- m_ack  in  1  address phase accepted
- m_rdv  in  1  read beat valid
- m_rdata  in  BEAT_BITS  read beat data
- fill_busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk.
  - On reset: state IDLE; b_dv_i=0, m_rd=0, fill_busy=0; line register, address latch and beat counter cleared to 0.
  - Reset mid-operation abandons the fill immediately. The memory subsystem shares rst_n, so no beats of the abandoned burst arrive after reset.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- States: IDLE, REQ, BEAT, DONE, DRAIN.
- IDLE:
  - If b_rd_i=1: latch b_addr_i, clear beat counter, go to REQ.
  - m_rdv in IDLE is ignored.
- REQ:
  - m_rd=1, m_addr driven from the latch.
  - Once asserted, m_rd stays high until m_ack, even if b_rd_i drops; an address phase is never withdrawn.
  - On m_ack: go to BEAT if b_rd_i=1, otherwise to DRAIN.
- BEAT:
  - Each cycle with m_rdv=1 writes m_rdata into line slot [cnt] and increments cnt.
  - Gaps (m_rdv=0) are allowed and have no effect.
  - On the beat where cnt==BEATS-1: go to DONE.
  - If b_rd_i=0 in any BEAT cycle: go to DRAIN. A beat arriving in that same cycle is still counted.
  - If the last beat and b_rd_i=0 coincide: go to IDLE, no pulse.
- DONE:
  - b_dv_i=1 for exactly one cycle; b_data_i holds the full line.
  - Always go to IDLE next cycle.
  - Latency from the last beat to b_dv_i is 1 cycle.
- DRAIN:
  - Beats are counted but discarded; the line register is not written.
  - After the beat where cnt==BEATS-1: go to IDLE. b_dv_i never pulses.
- b_data_i stays stable between fills; it changes only on beat writes.
- Minimum fill latency: request cycle t, m_ack at t+1, beats at t+2..t+1+BEATS, b_dv_i at t+2+BEATS.
- Back-to-back fills:
  - A new request is accepted in the IDLE cycle following DONE.
  - The cache drops b_rd_i in the DONE+1 cycle, so no duplicate fill is issued.
- Address changes on b_addr_i after the latch are ignored until the next IDLE acceptance.
- m_ack outside REQ is ignored.
- The beat counter wraps modulo BEATS; it is reset at IDLE acceptance.

Test Plan:
- Basic fill:
  - Stimulus: b_addr_i=0x40, b_rd_i=1; m_ack next cycle; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 consecutive.
  - Required: m_addr=0x800, m_len=3.
  - Required: b_dv_i is a single pulse 1 cycle after the 4th beat, with b_data_i={0x44..44,0x33..33,0x22..22,0x11..11}.
- Delayed ack and gapped beats:
  - Stimulus: m_ack after 5 cycles; m_rdv pattern 1,0,0,1,1,0,1.
  - Required: m_rd held for all 5 cycles; correct line assembly; b_dv_i exactly once.
- Abort mid-burst:
  - Stimulus: b_rd_i drops after beat 2 of 4.
  - Required: DRAIN consumes the remaining 2 beats; b_dv_i stays 0; line register keeps beats 0-1 of this fill and old data above; fill_busy falls after beat 4.
- Abort in REQ:
  - Stimulus: b_rd_i drops before m_ack.
  - Required: m_rd stays high until m_ack; all 4 beats drained; no b_dv_i.
- Back-to-back fills:
  - Stimulus: second request at addresses 0x40 then 0x41 in the cycle after DONE.
  - Required: second m_addr=0x820; two distinct pulses; no third request issued.
- Reset mid-operation:
  - Stimulus: rst_n=0 for 1 cycle during BEAT.
  - Required: next cycle state IDLE, m_rd=0, b_dv_i=0, b_data_i=0; a fresh request afterwards completes normally.
